dma_host_responder: RTL and testbench

//  Host-side counterpart of the DMA controller's CPU/system-bus interface: answers HRQ with HLDA and acts as memory.
//  - Hold arbiter: grants the bus to the DMA controller after a programmable CPU release delay.
//  - Memory slave: latches the 16-bit DMA address and serves MEMR_N/MEMW_N strobes.
//  - Inserts programmable wait states by driving READY low.
//  - Used as the system-side model in the DMA controller testbench and in the top-level integration.

---
 rtl/dma_host_responder.sv | 197 +++++++++++++++++++
 tb/tb_dma_host_responder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_host_responder.sv
// Host-side bus model for a DMA controller: hold arbiter plus byte memory with wait states.
// Optional hold watchdog is enabled by defining HOLD_TIMEOUT_EN.
module dma_host_responder #(
  parameter int unsigned HOLD_DELAY  = 2,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned MAX_HOLD    = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_hrq,
  output logic        o_hlda,
  input  logic        i_aen,
  input  logic        i_adstb,
  input  logic [3:0]  i_addr_up,
  input  logic [3:0]  i_addr_lo,
  input  logic        i_memr_n,
  input  logic        i_memw_n,
  output logic        o_ready,
  inout  wire  [7:0]  io_db,
  input  logic [15:0] i_mon_addr,
  output logic [7:0]  o_mon_data,
  output logic        o_hold_err
);

  localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {ArbIdle, ArbRelease, ArbGrant} arb_state_e;
  typedef enum logic [1:0] {AccIdle, AccWait, AccActive} acc_state_e;

  arb_state_e r_arb_state, w_arb_next;
  logic [15:0] r_hold_cnt, w_hold_cnt_next;

  acc_state_e r_acc_state, w_acc_next;
  logic [15:0] r_wait_cnt, w_wait_cnt_next;
  logic [AW-1:0] r_addr;
  logic r_is_write;
  logic [7:0] r_wdata;
  logic [7:0] r_upa;
  logic [7:0] r_mem [MEM_DEPTH];

  logic [15:0] w_acc_addr;
  logic w_en, w_strobe, w_released, w_capture, w_mem_we;
  logic w_db_oe;
  logic [7:0] w_rdata;
  logic w_unused_bits;

  // Arbiter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_arb_state <= ArbIdle;
      r_hold_cnt  <= '0;
    end else begin
      r_arb_state <= w_arb_next;
      r_hold_cnt  <= w_hold_cnt_next;
    end
  end

  always_comb begin
    w_arb_next      = r_arb_state;
    w_hold_cnt_next = r_hold_cnt;
    case (r_arb_state)
      ArbIdle: begin
        if (i_hrq) begin
          w_arb_next      = ArbRelease;
          w_hold_cnt_next = 16'(HOLD_DELAY - 1);
        end
      end
      ArbRelease: begin
        if (!i_hrq) begin
          w_arb_next = ArbIdle;
        end else if (r_hold_cnt == '0) begin
          w_arb_next = ArbGrant;
        end else begin
          w_hold_cnt_next = r_hold_cnt - 16'd1;
        end
      end
      ArbGrant: begin
        if (!i_hrq) w_arb_next = ArbIdle;
      end
      default: w_arb_next = ArbIdle;
    endcase
  end

  assign o_hlda = (r_arb_state == ArbGrant);

  // Upper address byte is carried on the data bus while ADSTB is high
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_upa <= '0;
    end else if (i_adstb) begin
      r_upa <= io_db;
    end
  end

  assign w_acc_addr = {r_upa, i_addr_up, i_addr_lo};
  assign w_en       = o_hlda & i_aen;
  assign w_strobe   = ~i_memr_n | ~i_memw_n;
  assign w_released = r_is_write ? i_memw_n : i_memr_n;

  // Access FSM
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc_state <= AccIdle;
      r_wait_cnt  <= '0;
      r_addr      <= '0;
      r_is_write  <= 1'b0;
      r_wdata     <= '0;
    end else begin
      r_acc_state <= w_acc_next;
      r_wait_cnt  <= w_wait_cnt_next;
      if (w_capture) begin
        r_addr     <= w_acc_addr[AW-1:0];
        r_is_write <= ~i_memw_n;
      end
      // Tracks the last byte seen while the write strobe is low
      if (!i_memw_n) r_wdata <= io_db;
    end
  end

  always_comb begin
    w_acc_next      = r_acc_state;
    w_wait_cnt_next = r_wait_cnt;
    w_capture       = 1'b0;
    w_mem_we        = 1'b0;
    case (r_acc_state)
      AccIdle: begin
        if (w_en && w_strobe) begin
          w_capture = 1'b1;
          if (WAIT_STATES == 0) begin
            w_acc_next = AccActive;
          end else begin
            w_acc_next      = AccWait;
            w_wait_cnt_next = 16'(WAIT_STATES - 1);
          end
        end
      end
      AccWait: begin
        if (!w_en || w_released) begin
          w_acc_next = AccIdle;
        end else if (r_wait_cnt == '0) begin
          w_acc_next = AccActive;
        end else begin
          w_wait_cnt_next = r_wait_cnt - 16'd1;
        end
      end
      AccActive: begin
        if (!w_en) begin
          w_acc_next = AccIdle;
        end else if (w_released) begin
          w_acc_next = AccIdle;
          w_mem_we   = r_is_write;
        end
      end
      default: w_acc_next = AccIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_mem_we) r_mem[r_addr] <= r_wdata;
  end

  assign w_rdata    = r_mem[r_addr];
  assign o_mon_data = r_mem[i_mon_addr[AW-1:0]];
  assign o_ready    = (r_acc_state != AccWait);

  // ADSTB owns the bus, so it always wins over a read drive
  assign w_db_oe = (r_acc_state == AccActive) & ~r_is_write & i_aen & ~i_adstb;
  assign io_db   = w_db_oe ? w_rdata : 8'hzz;

`ifdef HOLD_TIMEOUT_EN
  logic [31:0] r_to_cnt;
  logic        r_hold_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_to_cnt   <= '0;
      r_hold_err <= 1'b0;
    end else if (r_arb_state == ArbGrant) begin
      if (r_to_cnt == 32'(MAX_HOLD - 1)) begin
        r_hold_err <= 1'b1;
      end else begin
        r_to_cnt <= r_to_cnt + 32'd1;
      end
    end else begin
      r_to_cnt <= '0;
    end
  end

  assign o_hold_err = r_hold_err;
`else
  assign o_hold_err = 1'b0;
`endif

  assign w_unused_bits = ^{w_acc_addr, i_mon_addr, 32'(MAX_HOLD)};

endmodule

// File: tb/tb_dma_host_responder.sv
// Randomised scoreboard bench for dma_host_responder: arbiter timing, wait states, reads, writes, aborts.
module tb_dma_host_responder;

  localparam int unsigned HD = 3;
  localparam int unsigned WS = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hrq, aen, adstb, memr_n, memw_n;
  logic [3:0]  addr_up, addr_lo;
  logic [15:0] mon_addr;
  logic [7:0]  tb_db;
  logic        tb_oe;
  wire  [7:0]  db;
  wire         hlda, ready, hold_err;
  wire  [7:0]  mon_data;

  assign db = tb_oe ? tb_db : 8'hzz;

  dma_host_responder #(
    .HOLD_DELAY (HD),
    .WAIT_STATES(WS),
    .MEM_DEPTH  (256),
    .MAX_HOLD   (16)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_hrq     (hrq),
    .o_hlda    (hlda),
    .i_aen     (aen),
    .i_adstb   (adstb),
    .i_addr_up (addr_up),
    .i_addr_lo (addr_lo),
    .i_memr_n  (memr_n),
    .i_memw_n  (memw_n),
    .o_ready   (ready),
    .io_db     (db),
    .i_mon_addr(mon_addr),
    .o_mon_data(mon_data),
    .o_hold_err(hold_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]  model [256];
  logic [15:0] wr_addrs [$];
  logic [7:0]  exp_q [$];
  logic        prev_oe = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: each new read drive pops one expected byte from the scoreboard
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (dut.w_db_oe && !prev_oe) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_drive: got %0h want no drive", db);
        end else begin
          check("rd_data", 32'(db), 32'(exp_q.pop_front()));
        end
      end
      if (adstb) check("adstb_no_drive", 32'(dut.w_db_oe), 32'd0);
    end
    prev_oe <= dut.w_db_oe;
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_grant();
    for (int k = 1; k <= int'(HD) + 1; k++) begin
      check("hlda_delay", 32'(hlda), (k > int'(HD)) ? 32'd1 : 32'd0);
      if (k <= int'(HD)) cyc();
    end
  endtask

  task automatic addr_phase(input logic [15:0] a);
    adstb   = 1'b1;
    tb_oe   = 1'b1;
    tb_db   = a[15:8];
    addr_up = a[7:4];
    addr_lo = a[3:0];
    cyc();
    adstb = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input bit both);
    int L;
    L = int'(WS) + 1 + int'($urandom_range(0, 2));
    addr_phase(a);
    memw_n = 1'b0;
    if (both) memr_n = 1'b0;
    tb_db = (L == 1) ? d : 8'($urandom);
    cyc();
    for (int k = 1; k <= L; k++) begin
      check("wr_ready", 32'(ready), (k <= int'(WS)) ? 32'd0 : 32'd1);
      check("wr_no_drive", 32'(dut.w_db_oe), 32'd0);
      if (k < L) begin
        tb_db = (k == L - 1) ? d : 8'($urandom);
      end else begin
        memw_n = 1'b1;
        memr_n = 1'b1;
        tb_oe  = 1'b0;
      end
      cyc();
    end
    check("wr_ready_end", 32'(ready), 32'd1);
    model[a[7:0]] = d;
    wr_addrs.push_back(a);
    mon_addr = {8'($urandom), a[7:0]};
    #1;
    check("mon_after_wr", 32'(mon_data), 32'(d));
  endtask

  task automatic bus_read(input logic [15:0] a);
    int L;
    L = int'(WS) + 1 + int'($urandom_range(0, 2));
    addr_phase(a);
    tb_oe  = 1'b0;
    memr_n = 1'b0;
    exp_q.push_back(model[a[7:0]]);
    cyc();
    for (int k = 1; k <= L; k++) begin
      check("rd_ready", 32'(ready), (k <= int'(WS)) ? 32'd0 : 32'd1);
      check("rd_drive", 32'(dut.w_db_oe), (k > int'(WS)) ? 32'd1 : 32'd0);
      if (k > int'(WS)) check("rd_db_hold", 32'(db), 32'(model[a[7:0]]));
      if (k == L) memr_n = 1'b1;
      cyc();
    end
    check("rd_release", 32'(dut.w_db_oe), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] a;
    logic        exp_err;
    rst_n = 1'b0; hrq = 1'b0; aen = 1'b0; adstb = 1'b0;
    memr_n = 1'b1; memw_n = 1'b1; addr_up = '0; addr_lo = '0;
    mon_addr = '0; tb_db = '0; tb_oe = 1'b0;
    repeat (3) cyc();
    check("rst_hlda", 32'(hlda), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_db_z", 32'(dut.w_db_oe), 32'd0);
    check("rst_hold_err", 32'(hold_err), 32'd0);
    rst_n = 1'b1;
    cyc();

    // Grant, release, immediate re-request with full delay
    hrq = 1'b1;
    cyc();
    expect_grant();
    repeat (3) begin
      cyc();
      check("hlda_hold", 32'(hlda), 32'd1);
    end
    hrq = 1'b0;
    cyc();
    check("hlda_release", 32'(hlda), 32'd0);
    hrq = 1'b1;
    cyc();
    expect_grant();
    hrq = 1'b0;
    cyc();
    check("hlda_release2", 32'(hlda), 32'd0);

    // Single-cycle request never grants
    hrq = 1'b1;
    cyc();
    hrq = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("pulse_no_hlda", 32'(hlda), 32'd0);
    end
    hrq = 1'b1;
    cyc();
    expect_grant();
    aen = 1'b1;

    // Directed accesses at 16'h1234
    bus_write(16'h1234, 8'hA5, 1'b0);
    mon_addr = 16'h1234;
    #1;
    check("mon_1234", 32'(mon_data), 32'hA5);
    bus_write(16'h1234, 8'h5A, 1'b0);
    bus_read(16'h1234);

    // Abort a write by dropping AEN during the active phase
    bus_write(16'h0010, 8'h77, 1'b0);
    addr_phase(16'h0010);
    memw_n = 1'b0;
    tb_db  = 8'hCC;
    cyc();
    for (int k = 1; k <= int'(WS) + 1; k++) cyc();
    aen = 1'b0;
    cyc();
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_db_z", 32'(dut.w_db_oe), 32'd0);
    memw_n = 1'b1;
    tb_oe  = 1'b0;
    cyc();
    aen = 1'b1;
    cyc();
    mon_addr = 16'h0010;
    #1;
    check("abort_mem_kept", 32'(mon_data), 32'h77);

    // Abort a read by dropping AEN once data is on the bus
    addr_phase(16'h1234);
    tb_oe  = 1'b0;
    memr_n = 1'b0;
    exp_q.push_back(model[8'h34]);
    cyc();
    for (int k = 1; k <= int'(WS) + 1; k++) cyc();
    aen = 1'b0;
    #1;
    check("rd_abort_z_now", 32'(dut.w_db_oe), 32'd0);
    cyc();
    check("rd_abort_ready", 32'(ready), 32'd1);
    memr_n = 1'b1;
    cyc();
    aen = 1'b1;
    cyc();

    // Randomised traffic
    for (int i = 0; i < 60; i++) begin
      if (wr_addrs.size() == 0 || $urandom_range(0, 2) == 0) begin
        bus_write(16'($urandom), 8'($urandom), ($urandom_range(0, 4) == 0));
      end else begin
        a = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
        bus_read({8'($urandom), a[7:0]});
      end
    end

    cyc();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
`ifdef HOLD_TIMEOUT_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    check("hold_err", 32'(hold_err), 32'(exp_err));
    hrq = 1'b0;
    cyc();
    check("final_release", 32'(hlda), 32'd0);
    check("hold_err_sticky", 32'(hold_err), 32'(exp_err));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
